// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between two
// requesters with round-robin arbitration. The winning command is registered
// onto the RAM pins. Read data comes back from the RAM two cycles after the
// grant and is flagged to the requester that issued the read.
//
// Optional feature: define RAM_ARB_CLEAR_EN to add an INIT state. After every
// reset, INIT writes zero to every RAM word before any grant is given. When the
// macro is not defined, the block goes straight to RUN and busy stays low.

module ram_port_arbiter #(
   parameter int AW = 2,
   parameter int DW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          busy,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   localparam int DEPTH = 2 ** AW;

   logic          run;
   logic          clr_issue;
   logic [AW-1:0] clr_addr;
   logic          last;
   logic          win0;
   logic          win1;
   logic          rd_tag0;
   logic          rd_tag1;

`ifdef RAM_ARB_CLEAR_EN
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // The sweep counter has one extra bit, so it can reach DEPTH without wrapping.
   localparam logic [AW:0] CLR_END = (AW+1)'(DEPTH);

   state_t        state;
   state_t        state_nxt;
   logic [AW:0]   clr_cnt;
   logic [AW:0]   clr_cnt_nxt;

   // State and sweep-counter register. Reset always restarts the clear sweep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_INIT;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // INIT issues one clear write per cycle. It moves to RUN once the counter
   // has passed the last word, which is one cycle after the final write.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      clr_issue   = 1'b0;
      run         = 1'b0;
      case (state)
         ST_INIT: begin
            if (clr_cnt < CLR_END) begin
               clr_issue   = 1'b1;
               clr_cnt_nxt = clr_cnt + (AW+1)'(1);
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            run = 1'b1;
         end
         default: begin
            state_nxt = ST_INIT;
         end
      endcase
   end

   assign clr_addr = clr_cnt[AW-1:0];
   assign busy     = (state == ST_INIT);
`else
   assign run       = 1'b1;
   assign clr_issue = 1'b0;
   assign clr_addr  = '0;
   assign busy      = 1'b0;
`endif

   // Round-robin choice. A lone requester always wins. When both request,
   // the one that was not granted last time wins.
   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      if (req0 && req1) begin
         if (last) begin
            win0 = 1'b1;
         end else begin
            win1 = 1'b1;
         end
      end else begin
         win0 = req0;
         win1 = req1;
      end
   end

   // Grants are combinational. They are held off during reset and while not in RUN.
   assign gnt0 = rst & run & win0;
   assign gnt1 = rst & run & win1;

   // Pointer to the last granted requester. It only moves when a grant is given.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (gnt0) begin
         last <= 1'b0;
      end else if (gnt1) begin
         last <= 1'b1;
      end
   end

   // RAM command register. Sources are, in order: the clear sweep, requester 0,
   // then requester 1. In an idle cycle only the write enable drops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
      end else if (clr_issue) begin
         ram_we   <= 1'b1;
         ram_addr <= clr_addr;
         ram_din  <= '0;
      end else if (gnt0) begin
         ram_we   <= we0;
         ram_addr <= addr0;
         ram_din  <= din0;
      end else if (gnt1) begin
         ram_we   <= we1;
         ram_addr <= addr1;
         ram_din  <= din1;
      end else begin
         ram_we   <= 1'b0;
      end
   end

   // Two-stage read tag pipeline. The first stage follows the command onto
   // the RAM pins. The second stage lines up with the RAM's registered output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_tag0 <= 1'b0;
         rd_tag1 <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rd_tag0 <= gnt0 & ~we0;
         rd_tag1 <= gnt1 & ~we1;
         rvalid0 <= rd_tag0;
         rvalid1 <= rd_tag1;
      end
   end

   // Both requesters see the RAM output. The rvalid strobe tells each one when to take it.
   assign rdata0 = ram_dout;
   assign rdata1 = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed stimulus for ram_port_arbiter.
// A behavioural RAM sits on the RAM pins. A reference model tracks the
// expected grants, RAM port values, memory contents and read returns.
// Follows RAM_ARB_CLEAR_EN the same way the design does.

module tb_ram_port_arbiter;

   localparam int AW    = 2;
   localparam int DW    = 2;
   localparam int DEPTH = 2 ** AW;
`ifdef RAM_ARB_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   typedef struct {
      int due;
      int who;
      int data;
   } rdExp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] din0, din1;
   logic          gnt0, gnt1, rvalid0, rvalid1, busy;
   logic [DW-1:0] rdata0, rdata1;
   logic          ramWe;
   logic [AW-1:0] ramAddr;
   logic [DW-1:0] ramDin;
   logic [DW-1:0] ramDout;

   logic [DW-1:0] ramMem [DEPTH];
   logic          memInitDone = 1'b0;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            lastModel = 1;
   logic [DW-1:0] memModel [DEPTH];
   logic          expWe = 1'b0;
   logic [AW-1:0] expAddr = '0;
   logic [DW-1:0] expDin = '0;
   rdExp_t        rdQ[$];
   bit            gotG0 = 1'b0;
   bit            gotG1 = 1'b0;

   ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .ram_we(ramWe), .ram_addr(ramAddr), .ram_din(ramDin), .ram_dout(ramDout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with registered read data, zeroed on the first edge.
   always @(posedge clk) begin
      if (!memInitDone) begin
         for (int i = 0; i < DEPTH; i++) ramMem[i] <= '0;
         memInitDone <= 1'b1;
      end else begin
         if (ramWe) ramMem[ramAddr] <= ramDin;
         ramDout <= ramMem[ramAddr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Checks one cycle at the falling edge and advances the model.
   // Returns just after the next rising edge.
   task automatic applyStimulus();
      bit     runNow;
      int     win;
      logic   e0, e1;
      int     ed;
      rdExp_t r;
      @(negedge clk);
      runNow = CLEAR_EN ? (cyc > DEPTH) : 1'b1;
      win = -1;
      if (runNow) begin
         if (req0 && req1) win = (lastModel == 0) ? 1 : 0;
         else if (req0) win = 0;
         else if (req1) win = 1;
      end
      e0 = 1'b0; e1 = 1'b0; ed = 0;
      if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
         r = rdQ.pop_front();
         ed = r.data;
         if (r.who == 0) e0 = 1'b1; else e1 = 1'b1;
      end
      checkOutput("gnt0", 32'(gnt0), 32'(win == 0));
      checkOutput("gnt1", 32'(gnt1), 32'(win == 1));
      checkOutput("busy", 32'(busy), 32'(!runNow));
      checkOutput("ramWe", 32'(ramWe), 32'(expWe));
      checkOutput("ramAddr", 32'(ramAddr), 32'(expAddr));
      checkOutput("ramDin", 32'(ramDin), 32'(expDin));
      checkOutput("rvalid0", 32'(rvalid0), 32'(e0));
      checkOutput("rvalid1", 32'(rvalid1), 32'(e1));
      if (e0) checkOutput("rdata0", 32'(rdata0), 32'(ed));
      if (e1) checkOutput("rdata1", 32'(rdata1), 32'(ed));
      gotG0 = (win == 0);
      gotG1 = (win == 1);
      if (win >= 0) begin
         logic          w;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         w = (win == 0) ? we0 : we1;
         a = (win == 0) ? addr0 : addr1;
         d = (win == 0) ? din0 : din1;
         expWe = w; expAddr = a; expDin = d;
         if (w) memModel[a] = d;
         else rdQ.push_back('{due: cyc + 2, who: win, data: int'(memModel[a])});
         lastModel = win;
      end else if (CLEAR_EN && cyc < DEPTH) begin
         expWe = 1'b1; expAddr = AW'(cyc); expDin = '0;
         memModel[cyc] = '0;
      end else begin
         expWe = 1'b0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Asserts reset at the current time, checks the reset values, then
   // releases reset one cycle later just after a rising edge.
   task automatic doReset();
      rst = 1'b0;
      gotG0 = 1'b0; gotG1 = 1'b0;
      rdQ.delete();
      @(negedge clk);
      checkOutput("rstGnt0", 32'(gnt0), 32'(0));
      checkOutput("rstGnt1", 32'(gnt1), 32'(0));
      checkOutput("rstRamWe", 32'(ramWe), 32'(0));
      checkOutput("rstRamAddr", 32'(ramAddr), 32'(0));
      checkOutput("rstRamDin", 32'(ramDin), 32'(0));
      checkOutput("rstRvalid0", 32'(rvalid0), 32'(0));
      checkOutput("rstRvalid1", 32'(rvalid1), 32'(0));
      checkOutput("rstBusy", 32'(busy), 32'(CLEAR_EN));
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0; lastModel = 1;
      expWe = 1'b0; expAddr = '0; expDin = '0;
   endtask

   // Steps until the given requester is granted, with a bounded wait.
   task automatic waitGrant(input int who);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         applyStimulus();
         got = (who == 0) ? gotG0 : gotG1;
      end
      if (!got) checkOutput("grantTimeout", 32'(0), 32'(1));
   endtask

   task automatic idleCycles(input int n);
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   // Random requesters. A pending request is held until it is granted.
   task automatic randomCycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (!req0 || gotG0) begin
            req0 = ($urandom_range(0, 99) < 60);
            we0 = 1'($urandom_range(0, 1));
            addr0 = AW'($urandom); din0 = DW'($urandom);
         end
         if (!req1 || gotG1) begin
            req1 = ($urandom_range(0, 99) < 60);
            we1 = 1'($urandom_range(0, 1));
            addr1 = AW'($urandom); din1 = DW'($urandom);
         end
         applyStimulus();
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) memModel[i] = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
      // Write request held from reset onward, then read back the same word.
      req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; din0 = 2'd3;
      doReset();
      waitGrant(0);
      we0 = 1'b0;
      waitGrant(0);
      idleCycles(3);

      // Both requesters hold reads, so grants must alternate.
      req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
      for (int i = 0; i < 8; i++) applyStimulus();
      idleCycles(3);

      // Requester 1 streams reads over every address.
      for (int a = 0; a < DEPTH; a++) begin
         req1 = 1'b1; we1 = 1'b0; addr1 = AW'(a);
         applyStimulus();
      end
      idleCycles(3);

      // Write by requester 0 followed right away by a read of the same word by requester 1.
      req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; din0 = 2'd2;
      applyStimulus();
      req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
      applyStimulus();
      idleCycles(3);

      randomCycles(400);

      // Reset in the cycle after a read grant. The read must never return.
      idleCycles(1);
      req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
      applyStimulus();
      req0 = 1'b0;
      doReset();
      idleCycles(12);

      randomCycles(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
